store_buffer: RTL and testbench

- Posted-write buffer between the MEM pipeline stage and the word-addressed data memory.
- Queues CPU stores in a small FIFO and drains them to memory one per cycle. Loads that hit a queued store get the data forwarded; loads that miss pass straight through to memory.
- Lets stores retire without waiting on memory writes, and keeps loads coherent with stores that have not yet reached memory.

---
 rtl/store_buffer.sv | 144 ++++++++++++++
 tb/tb_store_buffer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-write store buffer with load forwarding between the MEM stage and data memory.
// Define STORE_BUFFER_COALESCE_EN to merge a store into the youngest queued entry with the same address.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          cpu_store,
  input  logic          cpu_load,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  output logic          buf_empty,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_writeData,
  output logic          mem_memWrite,
  output logic          mem_memRead,
  input  logic [DW-1:0] mem_readData
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          full;
  logic          loadActive;
  logic          hit;
  logic          loadMiss;
  logic          drain;
  logic          append;
  logic          stall;
  logic          wrEn;
  logic [PW-1:0] wrIdx;
  logic [DW-1:0] hitData;
`ifdef STORE_BUFFER_COALESCE_EN
  logic [PW-1:0] hitIdx;
  logic          coalesce;
`endif

  // Scan oldest to youngest so the last match found is the youngest one.
  always_comb begin
    hit     = 1'b0;
    hitData = '0;
`ifdef STORE_BUFFER_COALESCE_EN
    hitIdx  = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count_q) && (addr_q[head_q + PW'(k)] == cpu_addr)) begin
        hit     = 1'b1;
        hitData = data_q[head_q + PW'(k)];
`ifdef STORE_BUFFER_COALESCE_EN
        hitIdx  = head_q + PW'(k);
`endif
      end
    end
  end

  always_comb begin
    full       = (count_q == CW'(DEPTH));
    loadActive = cpu_load & ~cpu_store;
    loadMiss   = loadActive & ~hit;
    drain      = (count_q != '0) & ~loadMiss;
`ifdef STORE_BUFFER_COALESCE_EN
    // A head entry leaving memory-side this cycle cannot absorb the store.
    coalesce   = cpu_store & hit & ~(drain & (hitIdx == head_q));
    stall      = cpu_store & ~coalesce & full;
    append     = cpu_store & ~coalesce & ~full;
    wrEn       = append | coalesce;
    wrIdx      = coalesce ? hitIdx : tail_q;
`else
    stall      = cpu_store & full;
    append     = cpu_store & ~full;
    wrEn       = append;
    wrIdx      = tail_q;
`endif
  end

  always_comb begin
    head_d  = drain ? head_q + PW'(1) : head_q;
    tail_d  = append ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    if (append && !drain) begin
      count_d = count_q + CW'(1);
    end else if (!append && drain) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is never reset; slots outside head..head+count are ignored.
  always_ff @(posedge CLK) begin
    if (wrEn) begin
      addr_q[wrIdx] <= cpu_addr;
      data_q[wrIdx] <= cpu_wdata;
    end
  end

  always_comb begin
    cpu_rdata     = '0;
    cpu_stall     = 1'b0;
    buf_empty     = 1'b1;
    mem_address   = '0;
    mem_writeData = '0;
    mem_memWrite  = 1'b0;
    mem_memRead   = 1'b0;
    if (reset) begin
      buf_empty = (count_q == '0);
      cpu_stall = stall;
      if (loadMiss) begin
        mem_memRead = 1'b1;
        mem_address = cpu_addr;
        cpu_rdata   = mem_readData;
      end else begin
        if (loadActive) begin
          cpu_rdata = hitData;
        end
        if (drain) begin
          mem_memWrite  = 1'b1;
          mem_address   = addr_q[head_q];
          mem_writeData = data_q[head_q];
        end
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized traffic
// against a queue-based reference model and a 256-word data memory.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic        cpuStore;
  logic        cpuLoad;
  logic [31:0] cpuAddr;
  logic [31:0] cpuWdata;
  logic [31:0] cpuRdata;
  logic        cpuStall;
  logic        bufEmpty;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        memWrite;
  logic        memRead;
  logic [31:0] memReadData;

  int compareCount = 0;
  int failCount    = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } entry_t;

  entry_t      modelQ[$];
  logic [31:0] refMem [256];
  logic [31:0] memArr [256];

  logic        expEmpty, expStall, expWr, expRd;
  logic [31:0] expAddr, expWdata, expRdata;

  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .CLK(clock),
    .reset(reset),
    .cpu_store(cpuStore),
    .cpu_load(cpuLoad),
    .cpu_addr(cpuAddr),
    .cpu_wdata(cpuWdata),
    .cpu_rdata(cpuRdata),
    .cpu_stall(cpuStall),
    .buf_empty(bufEmpty),
    .mem_address(memAddress),
    .mem_writeData(memWriteData),
    .mem_memWrite(memWrite),
    .mem_memRead(memRead),
    .mem_readData(memReadData)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] bgWord(int i);
    if (i == 3) return 32'h0000DEAD;
    return 32'hB000_0000 | 32'(i);
  endfunction

  // Data memory: asynchronous read, write committed on the falling edge.
  assign memReadData = memArr[memAddress[7:0]];
  initial begin
    for (int i = 0; i < 256; i++) memArr[i] = bgWord(i);
    forever begin
      @(negedge clock);
      if (memWrite) memArr[memAddress[7:0]] = memWriteData;
    end
  end

  always @(posedge clock) begin
    if (reset) assert (!(cpuStore && cpuLoad)) else $error("[TB] illegal simultaneous store and load");
  end

  // Drive one cycle, predict outputs from the model, then advance the model.
  task automatic applyStimulus(input logic rstN, input logic st, input logic ld,
                               input logic [31:0] a, input logic [31:0] wd);
    logic        loadAct, hitF, miss, drn, coal;
    int          hitPos;
    logic [31:0] hitData;
    @(posedge clock);
    #1;
    reset = rstN; cpuStore = st; cpuLoad = ld; cpuAddr = a; cpuWdata = wd;
    expEmpty = 1'b1; expStall = 1'b0; expWr = 1'b0; expRd = 1'b0;
    expAddr = '0; expWdata = '0; expRdata = '0;
    hitF = 1'b0; hitPos = -1; hitData = '0; coal = 1'b0; drn = 1'b0;
    if (rstN) begin
      loadAct = ld && !st;
      foreach (modelQ[i]) begin
        if (modelQ[i].a == a) begin hitF = 1'b1; hitPos = i; hitData = modelQ[i].d; end
      end
      miss = loadAct && !hitF;
      drn  = (modelQ.size() > 0) && !miss;
      expEmpty = (modelQ.size() == 0);
`ifdef STORE_BUFFER_COALESCE_EN
      coal = st && hitF && !(hitPos == 0 && drn);
`endif
      expStall = st && !coal && (modelQ.size() == DEPTH);
      if (miss) begin
        expRd = 1'b1; expAddr = a; expRdata = refMem[a[7:0]];
      end else begin
        if (loadAct) expRdata = hitData;
        if (drn) begin expWr = 1'b1; expAddr = modelQ[0].a; expWdata = modelQ[0].d; end
      end
    end
    #3;
    if (!rstN) begin
      modelQ.delete();
    end else begin
      if (coal) modelQ[hitPos].d = wd;
      if (drn) begin refMem[modelQ[0].a[7:0]] = modelQ[0].d; void'(modelQ.pop_front()); end
      if (st && !coal && !expStall) modelQ.push_back('{a: a, d: wd});
    end
  endtask

  task automatic test_reset();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd5, 32'h77);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd3, 32'h0);
    compareCount++; if (bufEmpty !== 1'b1) begin failCount++; $display("[TB] FAIL reset_empty got %b want 1", bufEmpty); end
    compareCount++; if (cpuStall !== 1'b0) begin failCount++; $display("[TB] FAIL reset_stall got %b want 0", cpuStall); end
    compareCount++; if (memWrite !== 1'b0) begin failCount++; $display("[TB] FAIL reset_wr got %b want 0", memWrite); end
    compareCount++; if (memRead !== 1'b0) begin failCount++; $display("[TB] FAIL reset_rd got %b want 0", memRead); end
    compareCount++; if (memAddress !== 32'h0) begin failCount++; $display("[TB] FAIL reset_addr got %h want 0", memAddress); end
    compareCount++; if (memWriteData !== 32'h0) begin failCount++; $display("[TB] FAIL reset_wdata got %h want 0", memWriteData); end
    compareCount++; if (cpuRdata !== 32'h0) begin failCount++; $display("[TB] FAIL reset_rdata got %h want 0", cpuRdata); end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'h0);
    compareCount++; if (bufEmpty !== 1'b1) begin failCount++; $display("[TB] FAIL post_reset_empty got %b want 1", bufEmpty); end
    compareCount++; if (memWrite !== 1'b0) begin failCount++; $display("[TB] FAIL post_reset_wr got %b want 0", memWrite); end
  endtask

  task automatic test_basic();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd5, 32'h11);
    compareCount++; if (memWrite !== 1'b0) begin failCount++; $display("[TB] FAIL basic_c0_wr got %b want 0", memWrite); end
    compareCount++; if (cpuStall !== 1'b0) begin failCount++; $display("[TB] FAIL basic_c0_stall got %b want 0", cpuStall); end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'h0);
    compareCount++; if (memWrite !== 1'b1) begin failCount++; $display("[TB] FAIL basic_c1_wr got %b want 1", memWrite); end
    compareCount++; if (memAddress !== 32'd5) begin failCount++; $display("[TB] FAIL basic_c1_addr got %h want 5", memAddress); end
    compareCount++; if (memWriteData !== 32'h11) begin failCount++; $display("[TB] FAIL basic_c1_wdata got %h want 11", memWriteData); end
    compareCount++; if (bufEmpty !== 1'b0) begin failCount++; $display("[TB] FAIL basic_c1_empty got %b want 0", bufEmpty); end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'h0);
    compareCount++; if (bufEmpty !== 1'b1) begin failCount++; $display("[TB] FAIL basic_c2_empty got %b want 1", bufEmpty); end
    compareCount++; if (memWrite !== 1'b0) begin failCount++; $display("[TB] FAIL basic_c2_wr got %b want 0", memWrite); end
    compareCount++; if (memArr[5] !== 32'h11) begin failCount++; $display("[TB] FAIL basic_mem5 got %h want 11", memArr[5]); end
  endtask

  task automatic test_load_miss_hit();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd8, 32'h55);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd3, 32'h0);
    compareCount++; if (cpuRdata !== 32'hDEAD) begin failCount++; $display("[TB] FAIL miss_rdata got %h want dead", cpuRdata); end
    compareCount++; if (memRead !== 1'b1) begin failCount++; $display("[TB] FAIL miss_rd got %b want 1", memRead); end
    compareCount++; if (memWrite !== 1'b0) begin failCount++; $display("[TB] FAIL miss_wr got %b want 0", memWrite); end
    compareCount++; if (memAddress !== 32'd3) begin failCount++; $display("[TB] FAIL miss_addr got %h want 3", memAddress); end
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd8, 32'h0);
    compareCount++; if (cpuRdata !== 32'h55) begin failCount++; $display("[TB] FAIL hit_rdata got %h want 55", cpuRdata); end
    compareCount++; if (memRead !== 1'b0) begin failCount++; $display("[TB] FAIL hit_rd got %b want 0", memRead); end
    compareCount++; if (memWrite !== 1'b1) begin failCount++; $display("[TB] FAIL hit_drain_wr got %b want 1", memWrite); end
    compareCount++; if (memAddress !== 32'd8) begin failCount++; $display("[TB] FAIL hit_drain_addr got %h want 8", memAddress); end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'h0);
    compareCount++; if (bufEmpty !== 1'b1) begin failCount++; $display("[TB] FAIL hit_after_empty got %b want 1", bufEmpty); end
  endtask

  // Load misses hold the drain back; every store cycle drains the previous entry.
  task automatic test_loads_block_drain();
    logic        tSt [9];
    logic        tLd [9];
    logic [31:0] tA  [9];
    logic [31:0] tD  [9];
    logic        eWr [9];
    logic [31:0] eA  [9];
    logic [31:0] eD  [9];
    tSt = '{1, 0, 0, 1, 0, 1, 1, 0, 0};
    tLd = '{0, 1, 1, 0, 1, 0, 0, 0, 0};
    tA  = '{32'd1, 32'd9, 32'd9, 32'd2, 32'd9, 32'd3, 32'd4, 32'd0, 32'd0};
    tD  = '{32'hA1, 32'h0, 32'h0, 32'hA2, 32'h0, 32'hA3, 32'hA4, 32'h0, 32'h0};
    eWr = '{0, 0, 0, 1, 0, 1, 1, 1, 0};
    eA  = '{32'd0, 32'd9, 32'd9, 32'd1, 32'd9, 32'd2, 32'd3, 32'd4, 32'd0};
    eD  = '{32'h0, 32'h0, 32'h0, 32'hA1, 32'h0, 32'hA2, 32'hA3, 32'hA4, 32'h0};
    for (int c = 0; c < 9; c++) begin
      applyStimulus(1'b1, tSt[c], tLd[c], tA[c], tD[c]);
      compareCount++; if (memWrite !== eWr[c]) begin failCount++; $display("[TB] FAIL order_wr[%0d] got %b want %b", c, memWrite, eWr[c]); end
      compareCount++; if (memAddress !== eA[c]) begin failCount++; $display("[TB] FAIL order_addr[%0d] got %h want %h", c, memAddress, eA[c]); end
      compareCount++; if (memWriteData !== eD[c]) begin failCount++; $display("[TB] FAIL order_wdata[%0d] got %h want %h", c, memWriteData, eD[c]); end
      if (tLd[c]) begin
        compareCount++; if (cpuRdata !== 32'hB000_0009) begin failCount++; $display("[TB] FAIL order_rdata[%0d] got %h want b0000009", c, cpuRdata); end
      end
    end
    compareCount++; if (bufEmpty !== 1'b1) begin failCount++; $display("[TB] FAIL order_empty got %b want 1", bufEmpty); end
  endtask

  task automatic test_youngest();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd7, 32'h22);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd7, 32'h33);
    compareCount++; if (memWriteData !== 32'h22) begin failCount++; $display("[TB] FAIL dup_first_wdata got %h want 22", memWriteData); end
    compareCount++; if (cpuStall !== 1'b0) begin failCount++; $display("[TB] FAIL dup_stall got %b want 0", cpuStall); end
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd7, 32'h0);
    compareCount++; if (cpuRdata !== 32'h33) begin failCount++; $display("[TB] FAIL dup_rdata got %h want 33", cpuRdata); end
    compareCount++; if (memRead !== 1'b0) begin failCount++; $display("[TB] FAIL dup_rd got %b want 0", memRead); end
    compareCount++; if (memWriteData !== 32'h33) begin failCount++; $display("[TB] FAIL dup_second_wdata got %h want 33", memWriteData); end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'h0);
    compareCount++; if (memArr[7] !== 32'h33) begin failCount++; $display("[TB] FAIL dup_mem7 got %h want 33", memArr[7]); end
  endtask

  task automatic test_reset_mid_drain();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h20, 32'hBB);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h21, 32'hCC);
    compareCount++; if (memWrite !== 1'b0) begin failCount++; $display("[TB] FAIL rstmid_wr got %b want 0", memWrite); end
    compareCount++; if (memAddress !== 32'h0) begin failCount++; $display("[TB] FAIL rstmid_addr got %h want 0", memAddress); end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    compareCount++; if (bufEmpty !== 1'b1) begin failCount++; $display("[TB] FAIL rstmid_empty got %b want 1", bufEmpty); end
    compareCount++; if (memWrite !== 1'b0) begin failCount++; $display("[TB] FAIL rstmid_after_wr got %b want 0", memWrite); end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    compareCount++; if (memArr[32] !== bgWord(32)) begin failCount++; $display("[TB] FAIL rstmid_mem20 got %h want %h", memArr[32], bgWord(32)); end
    compareCount++; if (memArr[33] !== bgWord(33)) begin failCount++; $display("[TB] FAIL rstmid_mem21 got %h want %h", memArr[33], bgWord(33)); end
  endtask

  task automatic test_random();
    int          r;
    logic        rst, st, ld;
    logic [31:0] a;
    for (int n = 0; n < 400; n++) begin
      r   = int'($urandom_range(0, 99));
      rst = (r >= 3);
      st  = (r >= 3 && r < 45);
      ld  = (r >= 45 && r < 80);
      a   = 32'($urandom_range(0, 15));
      applyStimulus(rst, st, ld, a, $urandom);
      compareCount++; if (bufEmpty !== expEmpty) begin failCount++; $display("[TB] FAIL rnd_empty[%0d] got %b want %b", n, bufEmpty, expEmpty); end
      compareCount++; if (cpuStall !== expStall) begin failCount++; $display("[TB] FAIL rnd_stall[%0d] got %b want %b", n, cpuStall, expStall); end
      compareCount++; if (memWrite !== expWr) begin failCount++; $display("[TB] FAIL rnd_wr[%0d] got %b want %b", n, memWrite, expWr); end
      compareCount++; if (memRead !== expRd) begin failCount++; $display("[TB] FAIL rnd_rd[%0d] got %b want %b", n, memRead, expRd); end
      compareCount++; if (memAddress !== expAddr) begin failCount++; $display("[TB] FAIL rnd_addr[%0d] got %h want %h", n, memAddress, expAddr); end
      compareCount++; if (memWriteData !== expWdata) begin failCount++; $display("[TB] FAIL rnd_wdata[%0d] got %h want %h", n, memWriteData, expWdata); end
      compareCount++; if (cpuRdata !== expRdata) begin failCount++; $display("[TB] FAIL rnd_rdata[%0d] got %h want %h", n, cpuRdata, expRdata); end
    end
    repeat (DEPTH + 2) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    for (int i = 0; i < 16; i++) begin
      compareCount++; if (memArr[i] !== refMem[i]) begin failCount++; $display("[TB] FAIL rnd_mem[%0d] got %h want %h", i, memArr[i], refMem[i]); end
    end
  endtask

  initial begin
    reset = 1'b0; cpuStore = 1'b0; cpuLoad = 1'b0; cpuAddr = '0; cpuWdata = '0;
    for (int i = 0; i < 256; i++) refMem[i] = bgWord(i);
    $display("[TB] store_buffer bench starting");
    test_reset();
    test_basic();
    test_load_miss_hit();
    test_loads_block_drain();
    test_youngest();
    test_reset_mid_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
